// File: rtl/regfile_scoreboard.sv
// Integer register file (x1..x31, x0 hardwired zero) with write bypass and a
// per-register busy scoreboard that flags RAW/WAW hazards for decode.
module regfile_scoreboard #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            complete_we,
  input  logic [4:0]      regwrite_addr,
  input  logic [XLEN-1:0] regwrite_data,
  input  logic            kill,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_use,
  input  logic            rs2_use,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  output logic [5:0]      inflight
);

  logic [XLEN-1:0] regs [32];
  logic [31:1]     busy;
  logic [5:0]      inflight_q;

  logic [31:0]     busy_ext;
  logic            wr_en;
  logic            ebusy_rs1;
  logic            ebusy_rs2;
  logic            ebusy_rd;
  logic            issue_ok;
  logic            inc;
  logic            dec;
  logic [31:1]     busy_next;
  logic [5:0]      inflight_next;

  // Bit 0 reads as a constant zero so x0 can never look busy.
  assign busy_ext = {busy, 1'b0};
  assign wr_en    = complete_we && (regwrite_addr != 5'd0);

  // A completion this cycle retires its register immediately for hazard purposes.
  assign ebusy_rs1 = busy_ext[rs1_addr] && !(wr_en && regwrite_addr == rs1_addr);
  assign ebusy_rs2 = busy_ext[rs2_addr] && !(wr_en && regwrite_addr == rs2_addr);
  assign ebusy_rd  = busy_ext[issue_rd] && !(wr_en && regwrite_addr == issue_rd);

  assign hazard = (rs1_use && ebusy_rs1) || (rs2_use && ebusy_rs2) ||
                  (issue_valid && ebusy_rd);

  assign issue_ok = issue_valid && !hazard && !kill && (issue_rd != 5'd0);

  // Re-issuing to a register that is completing this cycle keeps the count flat.
  assign inc = issue_ok && !busy_ext[issue_rd];
  assign dec = wr_en && busy_ext[regwrite_addr] &&
               !(issue_ok && issue_rd == regwrite_addr);

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (complete_we && regwrite_addr == rs1_addr) rs1_data = regwrite_data;
      else                                          rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (complete_we && regwrite_addr == rs2_addr) rs2_data = regwrite_data;
      else                                          rs2_data = regs[rs2_addr];
    end
  end

  always_comb begin
    busy_next = busy;
    if (wr_en)    busy_next[regwrite_addr] = 1'b0;
    // Applied after the clear: the issuing instruction owns the register.
    if (issue_ok) busy_next[issue_rd] = 1'b1;
    if (kill)     busy_next = '0;
  end

  always_comb begin
    inflight_next = inflight_q;
    unique case ({inc, dec})
      2'b10:   inflight_next = inflight_q + 6'd1;
      2'b01:   inflight_next = inflight_q - 6'd1;
      default: inflight_next = inflight_q;
    endcase
    if (kill) inflight_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is reset explicitly because reads of x1..x31 must be zero
      // right after reset; this rules out mapping it onto a plain SRAM macro.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      busy       <= '0;
      inflight_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wr_en) regs[regwrite_addr] <= regwrite_data;
      busy       <= busy_next;
      inflight_q <= inflight_next;
    end
  end

  assign inflight = inflight_q;

endmodule
